// File: rtl/mem_burst_master.sv
// ---------------------------------------------------------------------------
// mem_burst_master
//   Bus initiator for a single-port memory with synchronous write and
//   asynchronous (combinational) read. Burst commands (addr, len, op) are
//   turned into registered mem_wr / mem_rd / mem_addr strobes. The master
//   owns the write side of the shared tristate data bus and exposes
//   valid/ready write-data and read-data streams to the core.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_write            1 = write burst, 0 = read burst
//   cmd_addr, cmd_len    burst start address, beats minus one
//   wdata/wvalid/wready  write-beat stream from the core
//   rdata/rvalid/rready  read-beat stream to the core (rdata registered)
//   busy                 high whenever the FSM is not in IDLE
//   done                 one-cycle pulse when a burst completes
//   mem_wr, mem_rd       registered memory strobes (never both high)
//   mem_addr             registered memory address, wraps mod 2**AWIDTH
//   mem_data             shared data bus, driven only while mem_wr is high
// ---------------------------------------------------------------------------
module mem_burst_master #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [AWIDTH-1:0] cmd_len,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    output logic [DWIDTH-1:0] rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              busy,
    output logic              done,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WLAST,
        S_READ,
        S_RDRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   cnt_q, cnt_d;          // beats remaining minus one
    logic [AWIDTH-1:0]   cur_addr_q, cur_addr_d; // next write address
    logic                mem_wr_q, mem_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                done_q, done_d;

    // Next-state and handshake logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_addr_d = cur_addr_q;
        mem_wr_d   = 1'b0;
        mem_rd_d   = mem_rd_q;
        mem_addr_d = mem_addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = rvalid_q;
        done_d     = 1'b0;
        cmd_ready  = 1'b0;
        wready     = 1'b0;

        // A beat held in rdata leaves as soon as the core takes it; a fresh
        // capture in READ below overrides this.
        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_d = cmd_len;
                    if (cmd_write) begin
                        cur_addr_d = cmd_addr;
                        state_d    = S_WRITE;
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = cmd_addr;
                        state_d    = S_READ;
                    end
                end
            end

            S_WRITE: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = cur_addr_q;
                    wdata_d    = wdata;
                    cur_addr_d = cur_addr_q + 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_WLAST;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            // Final write is on the bus this cycle; strobe drops at the edge.
            S_WLAST: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            // mem_data is valid combinationally from mem_addr while mem_rd is
            // high, so a capture slot is free whenever the output register is
            // empty or being emptied this cycle.
            S_READ: begin
                if (!rvalid_q || rready) begin
                    rdata_d    = mem_data;
                    rvalid_d   = 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                    if (cnt_q == '0) begin
                        mem_rd_d = 1'b0;
                        state_d  = S_RDRAIN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            S_RDRAIN: begin
                if (rvalid_q && rready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and strobe registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_addr_q <= '0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_addr_q <= cur_addr_d;
            mem_wr_q   <= mem_wr_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            done_q     <= done_d;
        end
    end

    // Write data register: only observable through the bus while mem_wr is
    // high, so it carries no reset.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
    end

    // Bus is released the moment mem_wr drops, including on async reset.
    assign mem_data = mem_wr_q ? wdata_q : {DWIDTH{1'bz}};

    assign mem_wr   = mem_wr_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule
